// File: rtl/esl_clk_check_pkg.sv
// Shared types for the clock-check sequencing controller: FSM state
// encoding, error cause codes and counter widths.
package esl_clk_check_pkg;

  // Width of the consecutive-failure counter (thresholds up to 7).
  localparam int FAIL_CNT_W = 3;

  // Width of the clear-phase cycle counter (clear lengths up to 15).
  localparam int CLR_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_SNAP  = 3'd3,
    ST_EVAL  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLOW    = 2'd1,
    ERR_FAST    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

endpackage

// File: rtl/esl_clk_check_ctrl.sv
// Clock-check sequencing controller (reference-clock domain).
// Clears the window and monitored-clock counters, runs one reference window,
// snapshots the monitored count, checks it against [MON_MIN, MON_MAX] and
// raises a sticky error after ERR_THRESHOLD consecutive failing windows.
// Optional feature: define ESL_CLK_CHECK_SNAP_TIMEOUT_EN to add a snapshot
// acknowledge timeout (SNAP_TIMEOUT cycles, reported as err_code 3).
module esl_clk_check_ctrl
  import esl_clk_check_pkg::*;
#(
  parameter int                    COUNT_BITS    = 25,
  parameter logic [COUNT_BITS-1:0] MON_MIN       = '0,
  parameter logic [COUNT_BITS-1:0] MON_MAX       = '1,
  parameter int                    CLR_CYCLES    = 4,
  parameter int                    ERR_THRESHOLD = 2,
  parameter int                    SNAP_TIMEOUT  = 64
) (
  input  logic                  ref_clk,
  input  logic                  ref_rst_n,
  input  logic                  start_check,
  input  logic                  err_clear,
  input  logic                  ref_clk_tc_reached,
  output logic                  reset_ref_clk_count,
  output logic                  en_ref_clk_count,
  output logic                  mon_count_clr,
  output logic                  mon_snap_req,
  input  logic                  mon_snap_ack,
  input  logic [COUNT_BITS-1:0] mon_count,
  output logic                  clk_ok,
  output logic                  clk_err,
  output logic [1:0]            err_code,
  output logic                  check_done
);

  localparam logic [CLR_CNT_W-1:0]  CLR_LAST   = CLR_CNT_W'(CLR_CYCLES - 1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_LIMIT = FAIL_CNT_W'(ERR_THRESHOLD);

  // Elaboration-time guard on the legal parameter ranges.
  if (CLR_CYCLES < 1 || CLR_CYCLES > 15 || ERR_THRESHOLD < 1 || ERR_THRESHOLD > 7 ||
      SNAP_TIMEOUT < 2 || SNAP_TIMEOUT > 255) begin : g_param_check
    $error("esl_clk_check_ctrl: parameter out of range");
  end

  state_e                  state_q, state_d;
  logic [CLR_CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [FAIL_CNT_W-1:0]   fail_inc;
  logic [COUNT_BITS-1:0]   snap_q, snap_d;
  err_code_e               err_code_q, err_code_d;
  err_code_e               eval_code;
  logic                    clk_ok_q, clk_ok_d;
  logic                    clk_err_q, clk_err_d;
  logic                    check_done_q, check_done_d;
  logic                    reset_ref_q, reset_ref_d;
  logic                    en_ref_q, en_ref_d;
  logic                    mon_clr_q, mon_clr_d;
  logic                    snap_req_q, snap_req_d;

`ifdef ESL_CLK_CHECK_SNAP_TIMEOUT_EN
  localparam logic [7:0] TMR_LAST = 8'(SNAP_TIMEOUT - 1);
  logic [7:0] tmr_q, tmr_d;
  logic       timed_out_q, timed_out_d;
`endif

  // Band check of a latched monitored count.
  function automatic err_code_e classify(input logic [COUNT_BITS-1:0] cnt,
                                         input logic [COUNT_BITS-1:0] lo,
                                         input logic [COUNT_BITS-1:0] hi);
    if (cnt < lo) return ERR_SLOW;
    if (cnt > hi) return ERR_FAST;
    return ERR_NONE;
  endfunction

  // Next-state, status and strobe computation; strobes follow the next state
  // so that every output is a registered Moore output aligned with its state.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    clr_cnt_d    = '0;
    fail_cnt_d   = fail_cnt_q;
    snap_d       = snap_q;
    clk_ok_d     = clk_ok_q;
    err_code_d   = err_code_q;
    check_done_d = 1'b0;
    eval_code    = classify(snap_q, MON_MIN, MON_MAX);
    fail_inc     = (fail_cnt_q == FAIL_LIMIT) ? FAIL_LIMIT : fail_cnt_q + 3'd1;
`ifdef ESL_CLK_CHECK_SNAP_TIMEOUT_EN
    tmr_d       = '0;
    timed_out_d = 1'b0;
    if (timed_out_q) eval_code = ERR_TIMEOUT;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_check) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!start_check)            state_d = ST_IDLE;
        else if (clr_cnt_q == CLR_LAST) state_d = ST_COUNT;
        else                         clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_COUNT: begin
        if (!start_check)            state_d = ST_IDLE;
        else if (ref_clk_tc_reached) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        if (!start_check) begin
          state_d = ST_IDLE;
        end else if (mon_snap_ack) begin
          snap_d  = mon_count;
          state_d = ST_EVAL;
        end
`ifdef ESL_CLK_CHECK_SNAP_TIMEOUT_EN
        else if (tmr_q == TMR_LAST) begin
          timed_out_d = 1'b1;
          state_d     = ST_EVAL;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
`endif
      end
      ST_EVAL: begin
        check_done_d = 1'b1;
        if (eval_code == ERR_NONE) begin
          fail_cnt_d = '0;
          clk_ok_d   = 1'b1;
          err_code_d = ERR_NONE;
          state_d    = start_check ? ST_CLEAR : ST_IDLE;
        end else begin
          fail_cnt_d = fail_inc;
          clk_ok_d   = 1'b0;
          err_code_d = eval_code;
          if (fail_inc == FAIL_LIMIT) state_d = ST_ERROR;
          else                        state_d = start_check ? ST_CLEAR : ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (err_clear) begin
          fail_cnt_d = '0;
          err_code_d = ERR_NONE;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    reset_ref_d = (state_d == ST_CLEAR);
    mon_clr_d   = (state_d == ST_CLEAR);
    en_ref_d    = (state_d == ST_COUNT);
    snap_req_d  = (state_d == ST_SNAP);
    clk_err_d   = (state_d == ST_ERROR);
  end

  // State, status and output registers.
  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      // NOTE: the snapshot is a data register but is still reset, so an
      // evaluation can never compare an unknown value.
      snap_q       <= '0;
      err_code_q   <= ERR_NONE;
      clk_ok_q     <= 1'b0;
      clk_err_q    <= 1'b0;
      check_done_q <= 1'b0;
      reset_ref_q  <= 1'b0;
      en_ref_q     <= 1'b0;
      mon_clr_q    <= 1'b0;
      snap_req_q   <= 1'b0;
`ifdef ESL_CLK_CHECK_SNAP_TIMEOUT_EN
      tmr_q        <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      snap_q       <= snap_d;
      err_code_q   <= err_code_d;
      clk_ok_q     <= clk_ok_d;
      clk_err_q    <= clk_err_d;
      check_done_q <= check_done_d;
      reset_ref_q  <= reset_ref_d;
      en_ref_q     <= en_ref_d;
      mon_clr_q    <= mon_clr_d;
      snap_req_q   <= snap_req_d;
`ifdef ESL_CLK_CHECK_SNAP_TIMEOUT_EN
      tmr_q        <= tmr_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

  assign reset_ref_clk_count = reset_ref_q;
  assign en_ref_clk_count    = en_ref_q;
  assign mon_count_clr       = mon_clr_q;
  assign mon_snap_req        = snap_req_q;
  assign clk_ok              = clk_ok_q;
  assign clk_err             = clk_err_q;
  assign err_code            = err_code_q;
  assign check_done          = check_done_q;

endmodule

// File: tb/tb_esl_clk_check_ctrl.sv
// Directed bench for esl_clk_check_ctrl. Expected window results are queued
// when the snapshot ack is driven and compared when check_done pulses.
module tb_esl_clk_check_ctrl;
  import esl_clk_check_pkg::*;

  localparam int CB = 25;

  typedef struct packed {
    logic       ok;
    logic [1:0] code;
    logic       err;
  } exp_t;

  logic          ref_clk = 1'b0;
  logic          ref_rst_n = 1'b1;
  logic          start_check = 1'b0;
  logic          err_clear = 1'b0;
  logic          ref_clk_tc_reached = 1'b0;
  logic          mon_snap_ack = 1'b0;
  logic [CB-1:0] mon_count = '0;
  logic          reset_ref_clk_count, en_ref_clk_count, mon_count_clr, mon_snap_req;
  logic          clk_ok, clk_err, check_done;
  logic [1:0]    err_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 ref_clk = ~ref_clk;

  esl_clk_check_ctrl #(
    .COUNT_BITS   (CB),
    .MON_MIN      (25'd90),
    .MON_MAX      (25'd110),
    .CLR_CYCLES   (4),
    .ERR_THRESHOLD(2),
    .SNAP_TIMEOUT (64)
  ) dut (
    .ref_clk            (ref_clk),
    .ref_rst_n          (ref_rst_n),
    .start_check        (start_check),
    .err_clear          (err_clear),
    .ref_clk_tc_reached (ref_clk_tc_reached),
    .reset_ref_clk_count(reset_ref_clk_count),
    .en_ref_clk_count   (en_ref_clk_count),
    .mon_count_clr      (mon_count_clr),
    .mon_snap_req       (mon_snap_req),
    .mon_snap_ack       (mon_snap_ack),
    .mon_count          (mon_count),
    .clk_ok             (clk_ok),
    .clk_err            (clk_err),
    .err_code           (err_code),
    .check_done         (check_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every check_done pulse must match the oldest queued result.
  always @(negedge ref_clk) begin : sb_monitor
    exp_t e;
    if (ref_rst_n && check_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_check_done", check_done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("sb_clk_ok", clk_ok, e.ok);
        check("sb_err_code", err_code, e.code);
        check("sb_clk_err", clk_err, e.err);
      end
    end
  end

  task automatic tick();
    @(negedge ref_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reset_ref"}, reset_ref_clk_count, 1'b0);
    check({tag, "_en_ref"}, en_ref_clk_count, 1'b0);
    check({tag, "_mon_clr"}, mon_count_clr, 1'b0);
    check({tag, "_snap_req"}, mon_snap_req, 1'b0);
    check({tag, "_clk_ok"}, clk_ok, 1'b0);
    check({tag, "_clk_err"}, clk_err, 1'b0);
    check({tag, "_err_code"}, err_code, 2'd0);
    check({tag, "_check_done"}, check_done, 1'b0);
  endtask

  // Counts the clear phase from the current negedge; ends in COUNT.
  task automatic count_clear(input string tag);
    int w = 0;
    int n = 0;
    while (!reset_ref_clk_count && w < 4) begin tick(); w++; end
    while (reset_ref_clk_count && n < 20) begin
      check({tag, "_mon_clr"}, mon_count_clr, 1'b1);
      n++;
      tick();
    end
    check({tag, "_clear_cycles"}, n, 4);
    check({tag, "_en_ref"}, en_ref_clk_count, 1'b1);
  endtask

  // One full window; returns at the negedge where check_done is high.
  task automatic run_window(input string tag, input logic [CB-1:0] cnt,
                            input exp_t e, input bit pulse_clr);
    int n;
    count_clear(tag);
    err_clear = pulse_clr;
    tick();
    err_clear = 1'b0;
    tick();
    ref_clk_tc_reached = 1'b1;
    tick();
    ref_clk_tc_reached = 1'b0;
    check({tag, "_snap_req"}, mon_snap_req, 1'b1);
    check({tag, "_en_drop"}, en_ref_clk_count, 1'b0);
    tick();
    tick();
    check({tag, "_snap_hold"}, mon_snap_req, 1'b1);
    sb_q.push_back(e);
    mon_count    = cnt;
    mon_snap_ack = 1'b1;
    tick();
    mon_snap_ack = 1'b0;
    mon_count    = 25'd5000;
    check({tag, "_snap_drop"}, mon_snap_req, 1'b0);
    n = 1;
    while (!check_done && n < 6) begin tick(); n++; end
    check({tag, "_done_latency"}, n, 2);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    #2 ref_rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    ref_rst_n = 1'b1;
    tick();
    check_all_zero("idle");

    // Start latency, then pass windows including both band edges.
    start_check = 1'b1;
    tick();
    check("start_to_clear", reset_ref_clk_count, 1'b1);
    run_window("pass100", 25'd100, '{ok: 1'b1, code: 2'd0, err: 1'b0}, 1'b0);
    run_window("pass_min", 25'd90, '{ok: 1'b1, code: 2'd0, err: 1'b0}, 1'b0);
    run_window("pass_max", 25'd110, '{ok: 1'b1, code: 2'd0, err: 1'b0}, 1'b0);

    // Fail, pass, fail: never reaches the threshold.
    run_window("slow89", 25'd89, '{ok: 1'b0, code: 2'd1, err: 1'b0}, 1'b0);
    run_window("pass_mid", 25'd100, '{ok: 1'b1, code: 2'd0, err: 1'b0}, 1'b0);
    run_window("fast111", 25'd111, '{ok: 1'b0, code: 2'd2, err: 1'b0}, 1'b0);

    // Second consecutive failure errors; err_clear outside ERROR is ignored.
    run_window("slow80_err", 25'd80, '{ok: 1'b0, code: 2'd1, err: 1'b1}, 1'b1);
    check("err_reset_ref", reset_ref_clk_count, 1'b0);
    check("err_en_ref", en_ref_clk_count, 1'b0);
    check("err_snap_req", mon_snap_req, 1'b0);
    check("err_mon_clr", mon_count_clr, 1'b0);
    tick(); tick(); tick();
    check("err_sticky", clk_err, 1'b1);
    check("err_code_held", err_code, 2'd1);
    check("err_no_clear", reset_ref_clk_count, 1'b0);

    // err_clear with start_check high: IDLE, then CLEAR.
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clr_clk_err", clk_err, 1'b0);
    check("clr_err_code", err_code, 2'd0);
    check("clr_idle", reset_ref_clk_count, 1'b0);
    tick();
    check("clr_restart", reset_ref_clk_count, 1'b1);

    // Two fast windows, then clear with start_check low.
    run_window("fast120a", 25'd120, '{ok: 1'b0, code: 2'd2, err: 1'b0}, 1'b0);
    run_window("fast120b", 25'd120, '{ok: 1'b0, code: 2'd2, err: 1'b1}, 1'b0);
    start_check = 1'b0;
    tick();
    check("fast_err_hold", clk_err, 1'b1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_all_zero("fast_cleared");
    tick();
    tick();
    check("stay_idle", reset_ref_clk_count, 1'b0);

    // Pass, then abort during COUNT: no evaluation, clk_ok kept.
    start_check = 1'b1;
    run_window("pass_pre_abort", 25'd100, '{ok: 1'b1, code: 2'd0, err: 1'b0}, 1'b0);
    count_clear("abort_count");
    start_check = 1'b0;
    tick();
    check("abort_en_ref", en_ref_clk_count, 1'b0);
    check("abort_reset_ref", reset_ref_clk_count, 1'b0);
    check("abort_clk_ok_kept", clk_ok, 1'b1);
    repeat (5) tick();

    // Abort during SNAP.
    start_check = 1'b1;
    count_clear("abort_snap");
    ref_clk_tc_reached = 1'b1;
    tick();
    ref_clk_tc_reached = 1'b0;
    check("abort_snap_req_on", mon_snap_req, 1'b1);
    start_check = 1'b0;
    tick();
    check("abort_snap_req_off", mon_snap_req, 1'b0);
    repeat (4) tick();

    // Failure, then reset mid-window clears the failure history.
    start_check = 1'b1;
    run_window("slow80_pre_rst", 25'd80, '{ok: 1'b0, code: 2'd1, err: 1'b0}, 1'b0);
    count_clear("rst_window");
    ref_rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    ref_rst_n = 1'b1;
    run_window("slow80_post_rst", 25'd80, '{ok: 1'b0, code: 2'd1, err: 1'b0}, 1'b0);

    // Snapshot ack never arrives.
    count_clear("no_ack");
    ref_clk_tc_reached = 1'b1;
    tick();
    ref_clk_tc_reached = 1'b0;
    check("no_ack_snap_req", mon_snap_req, 1'b1);
`ifdef ESL_CLK_CHECK_SNAP_TIMEOUT_EN
    sb_q.push_back('{ok: 1'b0, code: 2'd3, err: 1'b1});
    n = 0;
    while (mon_snap_req && n < 300) begin n++; tick(); end
    check("timeout_cycles", n, 64);
    tick();
    check("timeout_done", check_done, 1'b1);
    start_check = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("timeout_cleared", clk_err, 1'b0);
`else
    n = 0;
    repeat (200) begin
      if (mon_snap_req) n++;
      tick();
    end
    check("snap_req_held", n, 200);
    check("no_timeout_code", err_code, 2'd1);
    start_check = 1'b0;
    tick();
    check("no_ack_abort", mon_snap_req, 1'b0);
`endif
    repeat (4) tick();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
